// File: rtl/tinysoc_pkg.sv
// rtl/tinysoc_pkg.sv - shared encodings for the sequencer and nibble packer
package tinysoc_pkg;

    localparam int NIB_W = 4;

    // Sequencer state; bit 1 set means the CPU is enabled (RUN, STEP).
    typedef enum logic [1:0] {
        ST_LOAD = 2'b00,
        ST_HALT = 2'b01,
        ST_RUN  = 2'b10,
        ST_STEP = 2'b11
    } state_e;

    typedef enum logic [1:0] {
        CMD_RELOAD = 2'b00,
        CMD_RUN    = 2'b01,
        CMD_HALT   = 2'b10,
        CMD_STEP   = 2'b11
    } cmd_e;

endpackage

// File: rtl/nibble_packer.sv
// rtl/nibble_packer.sv - packs accepted nibbles LSB-first into instruction words
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   clr_i         synchronous clear of the packing counter
//   accept_i      a nibble is accepted this cycle
//   nib_i         nibble data
//   word_valid_o  one-cycle pulse the cycle after the last nibble of a word
//   word_o        assembled word, stable while word_valid_o is high
module nibble_packer
    import tinysoc_pkg::*;
#(
    parameter int INSTR_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr_i,
    input  logic                   accept_i,
    input  logic [NIB_W-1:0]       nib_i,
    output logic                   word_valid_o,
    output logic [INSTR_WIDTH-1:0] word_o
);

    localparam int NPW   = INSTR_WIDTH / NIB_W;
    localparam int CNT_W = (NPW > 1) ? $clog2(NPW) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NPW - 1);

    logic [CNT_W-1:0]       cnt_q;
    logic [INSTR_WIDTH-1:0] hold_q;
    logic [INSTR_WIDTH-1:0] assembled;
    logic                   word_valid_q;
    logic [INSTR_WIDTH-1:0] word_q;

    // The final nibble goes straight into the output word, so the holding
    // register is free to take the next word's first nibble during the write.
    always_comb begin
        assembled = hold_q;
        assembled[INSTR_WIDTH-1 -: NIB_W] = nib_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            hold_q       <= '0;
            word_valid_q <= 1'b0;
            word_q       <= '0;
        end else begin
            word_valid_q <= 1'b0;
            if (clr_i) begin
                cnt_q <= '0;
            end else if (accept_i) begin
                for (int k = 0; k < NPW; k++) begin
                    if (cnt_q == CNT_W'(k)) begin
                        hold_q[k*NIB_W +: NIB_W] <= nib_i;
                    end
                end
                if (cnt_q == LAST_CNT) begin
                    cnt_q        <= '0;
                    word_valid_q <= 1'b1;
                    word_q       <= assembled;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    assign word_valid_o = word_valid_q;
    assign word_o       = word_q;

endmodule

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - loads instruction memory from a nibble stream, then runs/halts/steps the CPU
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   nib_valid/nib_data   program nibble stream, nib_ready high only in LOAD
//   cmd_valid/cmd        RELOAD/RUN/HALT/STEP command
//   imem_wr/waddr/wdata  instruction-memory write port
//   cpu_en               CPU enable (RUN, STEP)
//   step_done            pulse in the first HALT cycle after a STEP
//   state                current sequencer state
module cpu_sequencer
    import tinysoc_pkg::*;
#(
    parameter int IMEM_DEPTH  = 8,
    parameter int INSTR_WIDTH = 16,
    parameter int AUTO_RUN    = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          nib_valid,
    input  logic [3:0]                    nib_data,
    output logic                          nib_ready,
    input  logic                          cmd_valid,
    input  logic [1:0]                    cmd,
    output logic                          imem_wr,
    output logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
    output logic [INSTR_WIDTH-1:0]        imem_wdata,
    output logic                          cpu_en,
    output logic                          step_done,
    output logic [1:0]                    state
);

    localparam int ADDR_W = $clog2(IMEM_DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMEM_DEPTH - 1);
    localparam state_e LOAD_EXIT = (AUTO_RUN != 0) ? ST_RUN : ST_HALT;

    state_e            state_q;
    logic [ADDR_W-1:0] waddr_q;
    logic              step_done_q;
    logic              accept_w;
    logic              reload_w;
    cmd_e              cmd_w;

    assign cmd_w    = cmd_e'(cmd);
    assign accept_w = nib_valid && (state_q == ST_LOAD);
    assign reload_w = cmd_valid && (cmd_w == CMD_RELOAD) &&
                      ((state_q == ST_HALT) || (state_q == ST_RUN));

    nibble_packer #(
        .INSTR_WIDTH (INSTR_WIDTH)
    ) u_packer (
        .clk          (clk),
        .rst          (rst),
        .clr_i        (reload_w),
        .accept_i     (accept_w),
        .nib_i        (nib_data),
        .word_valid_o (imem_wr),
        .word_o       (imem_wdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_LOAD;
            waddr_q     <= '0;
            step_done_q <= 1'b0;
        end else begin
            step_done_q <= (state_q == ST_STEP);
            case (state_q)
                // Commands are not looked at here, including during the final write.
                ST_LOAD: begin
                    if (imem_wr) begin
                        if (waddr_q == LAST_ADDR) begin
                            waddr_q <= '0;
                            state_q <= LOAD_EXIT;
                        end else begin
                            waddr_q <= waddr_q + 1'b1;
                        end
                    end
                end
                ST_HALT: begin
                    if (cmd_valid) begin
                        case (cmd_w)
                            CMD_RUN:    state_q <= ST_RUN;
                            CMD_STEP:   state_q <= ST_STEP;
                            CMD_RELOAD: begin
                                state_q <= ST_LOAD;
                                waddr_q <= '0;
                            end
                            default:    state_q <= ST_HALT;
                        endcase
                    end
                end
                ST_RUN: begin
                    if (cmd_valid) begin
                        case (cmd_w)
                            CMD_HALT:   state_q <= ST_HALT;
                            CMD_RELOAD: begin
                                state_q <= ST_LOAD;
                                waddr_q <= '0;
                            end
                            default:    state_q <= ST_RUN;
                        endcase
                    end
                end
                default: state_q <= ST_HALT;
            endcase
        end
    end

    assign state      = state_q;
    assign imem_waddr = waddr_q;
    assign nib_ready  = (state_q == ST_LOAD);
    assign cpu_en     = state_q[1];
    assign step_done  = step_done_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - directed self-checking bench for cpu_sequencer
module tb_cpu_sequencer;
    import tinysoc_pkg::*;

    logic        clk;
    logic        rst;
    logic        nib_valid;
    logic [3:0]  nib_data;
    logic        nib_ready;
    logic        cmd_valid;
    logic [1:0]  cmd;
    logic        imem_wr;
    logic [2:0]  imem_waddr;
    logic [15:0] imem_wdata;
    logic        cpu_en;
    logic        step_done;
    logic [1:0]  state;

    int n_checks = 0;
    int n_errors = 0;

    cpu_sequencer #(
        .IMEM_DEPTH  (8),
        .INSTR_WIDTH (16),
        .AUTO_RUN    (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .nib_valid  (nib_valid),
        .nib_data   (nib_data),
        .nib_ready  (nib_ready),
        .cmd_valid  (cmd_valid),
        .cmd        (cmd),
        .imem_wr    (imem_wr),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .cpu_en     (cpu_en),
        .step_done  (step_done),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [1:0] c);
        cmd_valid = 1'b1;
        cmd       = c;
        step_clk();
        cmd_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"}, state, ST_LOAD);
        check({tag, "_ready"}, nib_ready, 1);
        check({tag, "_wr"}, imem_wr, 0);
        check({tag, "_waddr"}, imem_waddr, 0);
        check({tag, "_wdata"}, imem_wdata, 0);
        check({tag, "_cpu_en"}, cpu_en, 0);
        check({tag, "_step_done"}, step_done, 0);
    endtask

    // Streams nwords words (base+i) nibble by nibble. gap=1 idles one cycle
    // after every nibble. final_cmd raises cmd=HALT during the last write.
    task automatic load_words(input logic [15:0] base, input int nwords, input bit gap,
                              input int start_addr, input bit final_cmd);
        logic [15:0] word;
        for (int w = 0; w < nwords; w++) begin
            word = base + 16'(w);
            for (int k = 0; k < 4; k++) begin
                nib_valid = 1'b1;
                nib_data  = word[4*k +: 4];
                step_clk();
                nib_valid = 1'b0;
                check("wr_strobe", imem_wr, (k == 3));
                if (k == 3) begin
                    check("wr_addr", imem_waddr, (start_addr + w) % 8);
                    check("wr_data", imem_wdata, word);
                    check("wr_cpu_en", cpu_en, 0);
                    if (final_cmd && (w == nwords - 1)) begin
                        cmd_valid = 1'b1;
                        cmd       = CMD_HALT;
                    end
                end
                if (gap) begin
                    step_clk();
                    cmd_valid = 1'b0;
                    check("gap_no_wr", imem_wr, 0);
                end
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        nib_valid = 1'b0;
        nib_data  = 4'h0;
        cmd_valid = 1'b0;
        cmd       = 2'b00;
        repeat (2) step_clk();
        check_reset_outputs("rst0");
        rst = 1'b0;
        step_clk();

        // Full back-to-back load, auto-run one cycle after the addr-7 write.
        load_words(16'hA0B0, 8, 1'b0, 0, 1'b0);
        check("load_state_wr7", state, ST_LOAD);
        step_clk();
        check("autorun_state", state, ST_RUN);
        check("autorun_cpu_en", cpu_en, 1);
        check("run_ready", nib_ready, 0);

        // STEP in RUN is ignored.
        send_cmd(CMD_STEP);
        check("step_in_run", state, ST_RUN);
        check("step_in_run_en", cpu_en, 1);

        // HALT, HALT again, then a single step.
        send_cmd(CMD_HALT);
        check("halt_state", state, ST_HALT);
        check("halt_cpu_en", cpu_en, 0);
        send_cmd(CMD_HALT);
        check("halt_in_halt", state, ST_HALT);
        nib_valid = 1'b1;
        nib_data  = 4'hF;
        step_clk();
        nib_valid = 1'b0;
        check("halt_nib_ignored", imem_wr, 0);
        send_cmd(CMD_STEP);
        check("step_state", state, ST_STEP);
        check("step_cpu_en", cpu_en, 1);
        check("step_done_early", step_done, 0);
        step_clk();
        check("after_step_state", state, ST_HALT);
        check("after_step_cpu_en", cpu_en, 0);
        check("step_done_pulse", step_done, 1);
        step_clk();
        check("step_done_clear", step_done, 0);
        check("still_halt", state, ST_HALT);

        // RELOAD from HALT, RUN during LOAD is ignored, then a gapped reload
        // with a HALT raised during the final write (also ignored).
        send_cmd(CMD_RELOAD);
        check("reload_state", state, ST_LOAD);
        check("reload_ready", nib_ready, 1);
        check("reload_cpu_en", cpu_en, 0);
        send_cmd(CMD_RUN);
        check("run_in_load", state, ST_LOAD);
        load_words(16'hA0B0, 8, 1'b1, 0, 1'b1);
        check("gapped_autorun", state, ST_RUN);
        check("gapped_cpu_en", cpu_en, 1);

        // RELOAD from RUN, one word, then reset two nibbles into the next word.
        send_cmd(CMD_RELOAD);
        check("reload_run_state", state, ST_LOAD);
        load_words(16'hC0DE, 1, 1'b0, 0, 1'b0);
        nib_valid = 1'b1;
        nib_data  = 4'h1;
        step_clk();
        nib_data  = 4'h2;
        step_clk();
        nib_valid = 1'b0;
        check("pre_rst_waddr", imem_waddr, 1);
        check("pre_rst_wdata", imem_wdata, 16'hC0DE);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_async");
        step_clk();
        check("rst_hold_wr", imem_wr, 0);
        rst = 1'b0;
        step_clk();
        load_words(16'h5A3C, 1, 1'b0, 0, 1'b0);
        step_clk();
        check("post_rst_waddr", imem_waddr, 1);
        check("post_rst_state", state, ST_LOAD);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
